// File: rtl/reaction_game_ctrl.sv
// Multi-round reaction game controller: difficulty select, target reveal, timed
// count-up and per-round scoring with running total and best (smallest) diff.
module reaction_game_ctrl #(
    parameter int NUM_W      = 14,
    parameter int LED_N      = 16,
    parameter int TICKS_EASY = 1000000,
    parameter int TICKS_REG  = 200000,
    parameter int TICKS_HARD = 100000,
    parameter int BAND       = 30,
    parameter int ROUNDS     = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               btnU,
    input  logic               btnD,
    input  logic               btnS,
    input  logic [NUM_W-1:0]   rand_val,
    output logic [1:0]         select,
    output logic [1:0]         mode,
    output logic [NUM_W-1:0]   number,
    output logic [LED_N-1:0]   led,
    output logic [3:0]         round,
    output logic [NUM_W+3:0]   total_score,
    output logic [NUM_W-1:0]   best_score
);
    localparam int T_MAX12 = (TICKS_EASY > TICKS_REG) ? TICKS_EASY : TICKS_REG;
    localparam int T_MAX   = (T_MAX12 > TICKS_HARD) ? T_MAX12 : TICKS_HARD;
    localparam int TICK_W  = (T_MAX > 1) ? $clog2(T_MAX) : 1;

    typedef enum logic [1:0] {
        ST_SETUP = 2'd0,
        ST_SHOW  = 2'd1,
        ST_COUNT = 2'd2,
        ST_SCORE = 2'd3
    } state_t;

    state_t            r_state, w_state_next;
    logic [1:0]        r_mode, w_mode_next;
    logic [NUM_W-1:0]  r_number, w_number_next;
    logic [NUM_W-1:0]  r_target, w_target_next;
    logic [NUM_W-1:0]  r_diff, w_diff_next;
    logic [NUM_W-1:0]  r_best, w_best_next;
    logic [TICK_W-1:0] r_tick, w_tick_next;
    logic [LED_N-1:0]  r_led, w_led_next;
    logic [3:0]        r_round, w_round_next;
    logic [NUM_W+3:0]  r_total, w_total_next;
    logic              r_score_pend, w_score_pend_next;
    logic              r_btnU_q, r_btnD_q, r_btnS_q;

    logic              w_press_u, w_press_d, w_press_s;
    logic [TICK_W-1:0] w_tick_last;
    logic [NUM_W-1:0]  w_number_inc;
    logic [NUM_W-1:0]  w_diff_now;
    logic [NUM_W+4:0]  w_sum;
    logic [NUM_W+3:0]  w_total_sat;
    logic [LED_N-1:0]  w_led_band;

    assign w_press_u = btnU & ~r_btnU_q;
    assign w_press_d = btnD & ~r_btnD_q;
    assign w_press_s = btnS & ~r_btnS_q;

    always_comb begin
        case (r_mode)
            2'd0:    w_tick_last = TICK_W'(TICKS_EASY - 1);
            2'd1:    w_tick_last = TICK_W'(TICKS_REG - 1);
            default: w_tick_last = TICK_W'(TICKS_HARD - 1);
        endcase
    end

    assign w_number_inc = (&r_number) ? r_number : r_number + NUM_W'(1);
    assign w_diff_now   = (r_number >= r_target) ? (r_number - r_target)
                                                 : (r_target - r_number);
    assign w_sum        = {1'b0, r_total} + {5'd0, r_diff};
    assign w_total_sat  = w_sum[NUM_W+4] ? '1 : w_sum[NUM_W+3:0];

    // LED gi stays lit when floor(diff/BAND) <= gi, i.e. diff < BAND*(gi+1).
    generate
        for (genvar gi = 0; gi < LED_N; gi++) begin : g_band
            localparam logic [31:0] LIMIT = 32'(BAND * (gi + 1));
            assign w_led_band[gi] = (32'(r_diff) < LIMIT);
        end
    endgenerate

    always_comb begin
        w_state_next      = r_state;
        w_mode_next       = r_mode;
        w_number_next     = r_number;
        w_target_next     = r_target;
        w_diff_next       = r_diff;
        w_best_next       = r_best;
        w_tick_next       = r_tick;
        w_led_next        = r_led;
        w_round_next      = r_round;
        w_total_next      = r_total;
        w_score_pend_next = r_score_pend;

        case (r_state)
            ST_SETUP: begin
                if (w_press_u && !w_press_d && (r_mode != 2'd2)) begin
                    w_mode_next = r_mode + 2'd1;
                end else if (w_press_d && !w_press_u && (r_mode != 2'd0)) begin
                    w_mode_next = r_mode - 2'd1;
                end
                if (w_press_s) begin
                    w_target_next = rand_val;
                    w_number_next = rand_val;
                    w_total_next  = '0;
                    w_round_next  = '0;
                    w_led_next    = '0;
                    w_state_next  = ST_SHOW;
                end
            end
            ST_SHOW: begin
                if (w_press_s) begin
                    w_number_next = '0;
                    w_tick_next   = '0;
                    w_state_next  = ST_COUNT;
                end
            end
            ST_COUNT: begin
                // A stop press wins over a count step landing on the same edge.
                if (w_press_s) begin
                    w_diff_next       = w_diff_now;
                    w_score_pend_next = 1'b1;
                    w_state_next      = ST_SCORE;
                end else if (r_tick == w_tick_last) begin
                    w_tick_next   = '0;
                    w_number_next = w_number_inc;
                end else begin
                    w_tick_next = r_tick + TICK_W'(1);
                end
            end
            ST_SCORE: begin
                if (r_score_pend) begin
                    w_led_next        = w_led_band;
                    w_total_next      = w_total_sat;
                    w_round_next      = r_round + 4'd1;
                    w_score_pend_next = 1'b0;
                    if (r_diff < r_best) begin
                        w_best_next = r_diff;
                    end
                end else if (w_press_s) begin
                    if (r_round < 4'(ROUNDS)) begin
                        w_target_next = rand_val;
                        w_number_next = rand_val;
                        w_led_next    = '0;
                        w_state_next  = ST_SHOW;
                    end else begin
                        w_number_next = '0;
                        w_state_next  = ST_SETUP;
                    end
                end
            end
            default: w_state_next = ST_SETUP;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_SETUP;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mode       <= 2'd1;
            r_number     <= '0;
            r_target     <= '0;
            r_diff       <= '0;
            r_best       <= '1;
            r_tick       <= '0;
            r_led        <= '0;
            r_round      <= '0;
            r_total      <= '0;
            r_score_pend <= 1'b0;
            r_btnU_q     <= 1'b0;
            r_btnD_q     <= 1'b0;
            r_btnS_q     <= 1'b0;
        end else begin
            r_mode       <= w_mode_next;
            r_number     <= w_number_next;
            r_target     <= w_target_next;
            r_diff       <= w_diff_next;
            r_best       <= w_best_next;
            r_tick       <= w_tick_next;
            r_led        <= w_led_next;
            r_round      <= w_round_next;
            r_total      <= w_total_next;
            r_score_pend <= w_score_pend_next;
            r_btnU_q     <= btnU;
            r_btnD_q     <= btnD;
            r_btnS_q     <= btnS;
        end
    end

    assign select      = r_state;
    assign mode        = r_mode;
    assign number      = r_number;
    assign led         = r_led;
    assign round       = r_round;
    assign total_score = r_total;
    assign best_score  = r_best;

endmodule

// File: tb/tb_reaction_game_ctrl.sv
// Scoreboard bench: stimulus tasks push predicted output snapshots (with the
// clock edge they must appear on); a monitor pops one per observed output change.
module tb_reaction_game_ctrl;
    localparam int NUM_W  = 14;
    localparam int LED_N  = 16;
    localparam int TE     = 10;
    localparam int TR     = 4;
    localparam int TH     = 2;
    localparam int BAND   = 30;
    localparam int ROUNDS = 3;
    localparam int NMAX   = (1 << NUM_W) - 1;
    localparam int TMAX   = (1 << (NUM_W + 4)) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic btnU = 1'b0, btnD = 1'b0, btnS = 1'b0;
    logic [NUM_W-1:0] rand_val = '0;
    logic [1:0]       select, mode;
    logic [NUM_W-1:0] number;
    logic [LED_N-1:0] led;
    logic [3:0]       round;
    logic [NUM_W+3:0] total_score;
    logic [NUM_W-1:0] best_score;

    logic b4U = 1'b0, b4D = 1'b0, b4S = 1'b0;
    logic [3:0]  r4 = '0;
    logic [1:0]  s4, m4;
    logic [3:0]  n4, rd4, bs4;
    logic [15:0] l4;
    logic [7:0]  t4;

    reaction_game_ctrl #(.NUM_W(NUM_W), .LED_N(LED_N), .TICKS_EASY(TE), .TICKS_REG(TR),
                         .TICKS_HARD(TH), .BAND(BAND), .ROUNDS(ROUNDS)) dut (
        .clk(clk), .rst(rst), .btnU(btnU), .btnD(btnD), .btnS(btnS), .rand_val(rand_val),
        .select(select), .mode(mode), .number(number), .led(led), .round(round),
        .total_score(total_score), .best_score(best_score));

    reaction_game_ctrl #(.NUM_W(4), .LED_N(16), .TICKS_EASY(TE), .TICKS_REG(TR),
                         .TICKS_HARD(TH), .BAND(BAND), .ROUNDS(ROUNDS)) dut4 (
        .clk(clk), .rst(rst), .btnU(b4U), .btnD(b4D), .btnS(b4S), .rand_val(r4),
        .select(s4), .mode(m4), .number(n4), .led(l4), .round(rd4),
        .total_score(t4), .best_score(bs4));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [1:0]       sel;
        logic [1:0]       md;
        logic [NUM_W-1:0] num;
        logic [LED_N-1:0] ld;
        logic [3:0]       rnd;
        logic [NUM_W+3:0] tot;
        logic [NUM_W-1:0] best;
    } snap_t;

    typedef struct {
        snap_t s;
        int    stamp;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;
    bit   mon_en = 1'b0;
    snap_t prev;

    // Behavioural model of the game, in plain integers.
    int m_sel = 0, m_mode = 1, m_number = 0, m_target = 0;
    int m_round = 0, m_total = 0, m_best = NMAX;
    logic [LED_N-1:0] m_led = '0;

    function automatic snap_t model_snap();
        snap_t s;
        s.sel  = 2'(m_sel);
        s.md   = 2'(m_mode);
        s.num  = NUM_W'(m_number);
        s.ld   = m_led;
        s.rnd  = 4'(m_round);
        s.tot  = (NUM_W+4)'(m_total);
        s.best = NUM_W'(m_best);
        return s;
    endfunction

    function automatic void push(int stamp);
        exp_t e;
        e.s = model_snap();
        e.stamp = stamp;
        q.push_back(e);
    endfunction

    function automatic int ticks_of(int md);
        return (md == 0) ? TE : ((md == 1) ? TR : TH);
    endfunction

    task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end else begin
            $display("ok   %s value=%0h", name, got);
        end
    endtask

    initial begin : monitor
        snap_t cur;
        exp_t  e;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                cur = {select, mode, number, led, round, total_score, best_score};
                if (cur !== prev) begin
                    checks++;
                    if (q.size() == 0) begin
                        failures++;
                        $display("FAIL unexpected_event cyc=%0d got=%h", cyc, cur);
                    end else begin
                        e = q.pop_front();
                        if (cur !== e.s || cyc != e.stamp) begin
                            failures++;
                            $display("FAIL event cyc=%0d got=%h exp=%h exp_cyc=%0d", cyc, cur, e.s, e.stamp);
                        end else begin
                            $display("ok   event cyc=%0d sel=%0d mode=%0d num=%0d led=%h round=%0d total=%0d best=%0d",
                                     cyc, select, mode, number, led, round, total_score, best_score);
                        end
                    end
                    prev = cur;
                end
            end
        end
    end

    task automatic pulse_btn(input bit u, input bit d, input bit s);
        btnU = u; btnD = d; btnS = s;
        @(negedge clk);
        btnU = 1'b0; btnD = 1'b0; btnS = 1'b0;
        @(negedge clk);
    endtask

    task automatic press_ud(input bit u, input bit d);
        int old = m_mode;
        if (u && !d && m_mode < 2) m_mode++;
        else if (d && !u && m_mode > 0) m_mode--;
        if (m_mode != old) push(cyc + 1);
        pulse_btn(u, d, 1'b0);
    endtask

    task automatic hold_up(input int n);
        if (m_mode < 2) begin
            m_mode++;
            push(cyc + 1);
        end
        btnU = 1'b1;
        repeat (n) @(negedge clk);
        btnU = 1'b0;
        @(negedge clk);
    endtask

    task automatic set_mode(input int md);
        while (m_mode < md) press_ud(1'b1, 1'b0);
        while (m_mode > md) press_ud(1'b0, 1'b1);
    endtask

    task automatic start_game(input int r);
        rand_val = NUM_W'(r);
        m_sel = 1; m_target = r; m_number = r; m_total = 0; m_round = 0; m_led = '0;
        push(cyc + 1);
        pulse_btn(1'b0, 1'b0, 1'b1);
    endtask

    // Count from 0 and stop so the frozen number equals stop_val.
    task automatic play_round(input int stop_val, input int extra);
        int t, n, e0, frozen, diff, k;
        t = ticks_of(m_mode);
        n = stop_val * t + 1 + extra;
        e0 = cyc + 1;
        m_sel = 2; m_number = 0;
        push(e0);
        btnS = 1'b1;
        @(negedge clk);
        btnS = 1'b0;
        for (int j = 1; (j * t < n) && (j <= NMAX); j++) begin
            m_number = j;
            push(e0 + j * t);
        end
        while (cyc < e0 + n - 1) @(negedge clk);
        frozen = ((n - 1) / t > NMAX) ? NMAX : (n - 1) / t;
        m_number = frozen;
        m_sel = 3;
        push(e0 + n);
        btnS = 1'b1;
        @(negedge clk);
        btnS = 1'b0;
        diff = (frozen > m_target) ? frozen - m_target : m_target - frozen;
        k = diff / BAND;
        for (int i = 0; i < LED_N; i++) m_led[i] = (i >= k) && (diff < BAND * LED_N);
        m_total = (m_total + diff > TMAX) ? TMAX : m_total + diff;
        if (diff < m_best) m_best = diff;
        m_round++;
        push(e0 + n + 1);
        @(negedge clk);
    endtask

    task automatic score_next(input int r);
        if (m_round < ROUNDS) begin
            rand_val = NUM_W'(r);
            m_sel = 1; m_target = r; m_number = r; m_led = '0;
        end else begin
            m_sel = 0; m_number = 0;
        end
        push(cyc + 1);
        pulse_btn(1'b0, 1'b0, 1'b1);
    endtask

    task automatic random_game(input int md);
        set_mode(md);
        start_game($urandom_range(0, 300));
        for (int r = 0; r < ROUNDS; r++) begin
            play_round($urandom_range(1, 150), $urandom_range(0, ticks_of(md) - 1));
            score_next($urandom_range(0, 300));
        end
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog_timeout cyc=%0d", cyc);
        $fatal(1, "bench timeout");
    end

    initial begin : stimulus
        int e0;
        repeat (3) @(negedge clk);
        chk("reset_select", select, 0);
        chk("reset_mode", mode, 1);
        chk("reset_number", number, 0);
        chk("reset_led", led, 0);
        chk("reset_round", round, 0);
        chk("reset_total", total_score, 0);
        chk("reset_best", best_score, NMAX);
        rst = 1'b0;
        prev = model_snap();
        mon_en = 1'b1;
        @(negedge clk);

        // Mode selection and edge detection.
        press_ud(1'b0, 1'b1);
        hold_up(20);
        repeat (3) press_ud(1'b1, 1'b0);
        repeat (4) press_ud(1'b0, 1'b1);
        press_ud(1'b1, 1'b1);
        chk("mode_updown_same", mode, 0);

        // Game A: diffs 60, 10, 200.
        set_mode(1);
        start_game(100);
        play_round(40, $urandom_range(0, TR - 1));
        chk("led_diff60", led, 16'hFFFC);
        score_next(100);
        play_round(110, $urandom_range(0, TR - 1));
        score_next(250);
        play_round(50, $urandom_range(0, TR - 1));
        chk("total_270", total_score, 270);
        chk("best_10", best_score, 10);
        chk("round_3", round, 3);
        score_next(0);
        chk("game_end_select", select, 0);

        // Game B: LED boundaries, best persists across games.
        set_mode(2);
        start_game(100);
        chk("newgame_total", total_score, 0);
        chk("newgame_round", round, 0);
        chk("best_persist", best_score, 10);
        play_round(100, $urandom_range(0, TH - 1));
        chk("led_diff0", led, 16'hFFFF);
        score_next(500);
        play_round(21, $urandom_range(0, TH - 1));
        chk("led_diff479", led, 16'h8000);
        score_next(600);
        play_round(120, $urandom_range(0, TH - 1));
        chk("led_diff480", led, 16'h0000);
        score_next(0);

        random_game(0);
        random_game($urandom_range(0, 2));
        chk("queue_drained_games", q.size(), 0);

        // Narrow instance: saturation of number.
        b4U = 1'b1; @(negedge clk); b4U = 1'b0; @(negedge clk);
        r4 = 4'd3;
        b4S = 1'b1; @(negedge clk); b4S = 1'b0; @(negedge clk);
        b4S = 1'b1; @(negedge clk); b4S = 1'b0; @(negedge clk);
        repeat (100) @(negedge clk);
        chk("n4_mode", m4, 2);
        chk("n4_saturate", n4, 15);
        b4S = 1'b1; @(negedge clk); b4S = 1'b0; @(negedge clk);
        chk("n4_select", s4, 3);
        chk("n4_frozen", n4, 15);
        chk("n4_led_diff12", l4, 16'hFFFF);
        chk("n4_total_12", t4, 12);
        chk("n4_best_12", bs4, 12);
        chk("n4_round", rd4, 1);

        // Asynchronous reset mid-COUNT with number=7.
        set_mode(1);
        start_game(50);
        e0 = cyc + 1;
        m_sel = 2; m_number = 0;
        push(e0);
        pulse_btn(1'b0, 1'b0, 1'b1);
        for (int j = 1; j <= 7; j++) begin
            m_number = j;
            push(e0 + j * TR);
        end
        while (cyc < e0 + 7 * TR + 1) @(negedge clk);
        chk("pre_reset_number", number, 7);
        chk("queue_drained_count", q.size(), 0);
        mon_en = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("async_select", select, 0);
        chk("async_number", number, 0);
        chk("async_led", led, 0);
        chk("async_mode", mode, 1);
        chk("async_best", best_score, NMAX);
        chk("async_round", round, 0);
        chk("async_total", total_score, 0);
        @(negedge clk);
        rst = 1'b0;
        m_sel = 0; m_mode = 1; m_number = 0; m_target = 0;
        m_round = 0; m_total = 0; m_best = NMAX; m_led = '0;
        q.delete();
        prev = model_snap();
        mon_en = 1'b1;
        @(negedge clk);
        press_ud(1'b1, 1'b0);
        repeat (4) @(negedge clk);
        chk("queue_drained_final", q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/reaction_game_ctrl.md
Name: reaction_game_ctrl

Overview:
Multi-round, parametrised controller for the reaction game: mode select, target reveal, timed count-up, and per-round scoring on an LED bar. It adds round sequencing, total and best score tracking, saturation handling, and single-clock button edge detection. It sits between the debounced button/LFSR sources and the seven-segment driver (select, number) and the LED array.

Parameters:
NUM_W, 14, width of target/number/diff
LED_N, 16, LED bar width
TICKS_EASY, 1000000, clk cycles per count step, mode 0
TICKS_REG, 200000, clk cycles per count step, mode 1
TICKS_HARD, 100000, clk cycles per count step, mode 2
BAND, 30, diff units per LED extinguished
ROUNDS, 3, rounds per game (1..15)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
btnU  in  1  up button, synchronous to clk, debounced level
btnD  in  1  down button, same
btnS  in  1  select button, same
rand  in  NUM_W  random value, sampled on target capture
select  out  2  phase: 0 SETUP, 1 SHOW, 2 COUNT, 3 SCORE
mode  out  2  difficulty 0..2
number  out  NUM_W  value for display
led  out  LED_N  score bar
round  out  4  completed rounds in current game
total_score  out  NUM_W+4  sum of diffs this game
best_score  out  NUM_W  smallest diff since reset

Behaviour:
- Reset: one clock, asynchronous active-high reset (rst); all state in the clk domain.
- Reset values: select=0, mode=1, number=0, led=0, round=0, total_score=0, best_score=all ones, tick=0, target=0, button history=0.
- Press detection: pressX = btnX & ~btnX_q; btnX_q is registered every cycle. One event per rising level; held buttons do not repeat. Each press acts on the next edge.
- SETUP: up press: mode+1, saturating at 2. Down press: mode-1, saturating at 0. Up and down in the same cycle: no change. Up/down ignored in all other states.
- SETUP + S press: target<=rand, number<=rand, total_score<=0, round<=0, led<=0, select<=1.
- SHOW: number holds target. S press: number<=0, tick<=0, select<=2.
- COUNT: tick increments each cycle. When tick==T(mode)-1: tick<=0, number<=number+1. T is the per-mode TICKS parameter. number saturates at 2^NUM_W-1.
- COUNT + S press: freeze number, diff<=|number-target| (NUM_W bits, no sign), select<=3. An S press takes priority over a same-cycle count step; the step is dropped.
- SCORE entry cycle (one cycle after the transition edge):
  - k = floor(diff/BAND).
  - led <= ~((1<<k)-1) if diff < BAND*LED_N, else led <= 0.
  - total_score += diff, saturating at all ones.
  - best_score <= diff if diff < best_score.
  - round += 1.
  - led, total_score, best_score and round are valid from the second cycle in SCORE.
- SCORE + S press, round < ROUNDS: target<=rand, number<=rand, led<=0, select<=1.
- SCORE + S press, round == ROUNDS: select<=0, number<=0. led, total_score and round hold until the next game start; best_score persists.
- An S press arriving before the SCORE update cycle completes is ignored.
- rst asserted mid-operation, in any state: all outputs return to reset values immediately, with no clock needed.
- k is computed with no divider IP; a constant-divide or compare chain is acceptable, provided it meets timing in one cycle.

Test Plan:
(Sim overrides: TICKS_EASY=10, TICKS_REG=4, TICKS_HARD=2, BAND=30, LED_N=16, ROUNDS=3.)
1. After reset: mode=1. Three up presses -> mode=2. Up held 20 cycles -> one step only. Four down presses -> mode=0. Up+down together -> mode stays 0.
2. mode=1, rand=100, S, S: number=0 on COUNT entry, 1 after 4 cycles, 5 after 20 cycles. mode=0: 1 after 10 cycles.
3. target=100, stop at 40: diff=60, k=2, led=16'hFFFC. Stop at 100: led=16'hFFFF. diff=479: led=16'h8000. diff=480: led=16'h0000.
4. Three rounds with diffs 60, 10, 200: total_score=270, best_score=10, round=3. Fourth S -> select=0. A new game clears total_score and round; best_score stays 10.
5. NUM_W=4, mode=2, left in COUNT 100 cycles: number sticks at 15. S from a target of 3 gives diff=12.
6. rst pulse mid-COUNT with number=7: select=0, number=0, led=0, mode=1, best_score=all ones, asserted asynchronously before the next clk edge.
